// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control unit: sequences fetch, decode, execute,
// memory and writeback through request/valid handshakes, with a sticky halt.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter bit ENABLE_TIMEOUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_wen,
  output logic [2:0]  dmem_funct3,
  input  logic        dmem_resp_valid,
  output logic        ir_wen,
  output logic        pc_wen,
  output logic        reg_wen,
  output logic [2:0]  imm_type,
  output logic        pc_src,
  output logic        a_src,
  output logic        b_src,
  output logic [3:0]  alu_op,
  output logic [1:0]  wb_src,
  output logic        halt,
  output logic        illegal,
  output logic        timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_OPI   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  state_t        r_state, w_next;
  logic [31:0]   r_ir;
  logic [CW-1:0] r_cnt;
  logic          r_ill, r_to;
  logic          w_set_ill, w_set_to;
  logic          w_lui, w_auipc, w_jal, w_jalr, w_br;
  logic          w_ld, w_st, w_opi, w_op;
  logic          w_known, w_ebreak, w_lim, w_wait;
  logic          w_ir_wen, w_fields_vld;
  logic [3:0]    w_alu;

  assign w_lui    = r_ir[6:0] == OP_LUI;
  assign w_auipc  = r_ir[6:0] == OP_AUIPC;
  assign w_jal    = r_ir[6:0] == OP_JAL;
  assign w_jalr   = r_ir[6:0] == OP_JALR;
  assign w_br     = r_ir[6:0] == OP_BR;
  assign w_ld     = r_ir[6:0] == OP_LD;
  assign w_st     = r_ir[6:0] == OP_ST;
  assign w_opi    = r_ir[6:0] == OP_OPI;
  assign w_op     = r_ir[6:0] == OP_OP;
  assign w_known  = w_lui | w_auipc | w_jal | w_jalr | w_br
                  | w_ld | w_st | w_opi | w_op;
  assign w_ebreak = r_ir == 32'h0010_0073;

  assign w_lim  = ENABLE_TIMEOUT && (r_cnt == CW'(TIMEOUT_CYCLES));
  assign w_wait = (r_state == S_FETCH && !inst_valid)
               || (r_state == S_MEM && !dmem_resp_valid);
  assign w_ir_wen = (r_state == S_FETCH) && inst_valid;
  assign w_fields_vld = (r_state == S_EXEC) || (r_state == S_MEM)
                     || (r_state == S_WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir  <= '0;
      r_cnt <= '0;
      r_ill <= 1'b0;
      r_to  <= 1'b0;
    end else begin
      if (w_ir_wen) r_ir <= inst;
      // any state change clears the wait count for the next handshake
      if (r_state != w_next) r_cnt <= '0;
      else if (w_wait)       r_cnt <= r_cnt + CW'(1);
      r_ill <= r_ill | w_set_ill;
      r_to  <= r_to | w_set_to;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_set_ill = 1'b0;
    w_set_to  = 1'b0;
    unique case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        if (inst_valid) w_next = S_DECODE;
        else if (w_lim) begin
          w_next   = S_HALT;
          w_set_to = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_ebreak) w_next = S_HALT;
        else if (!w_known) begin
          w_next    = S_HALT;
          w_set_ill = 1'b1;
        end else w_next = S_EXEC;
      end
      S_EXEC: w_next = (w_ld | w_st) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_resp_valid) w_next = w_ld ? S_WB : S_FETCH;
        else if (w_lim) begin
          w_next   = S_HALT;
          w_set_to = 1'b1;
        end
      end
      S_WB:    w_next = S_FETCH;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_alu = 4'd0;
    case (r_ir[14:12])
      3'b000:  w_alu = (w_op && r_ir[30]) ? 4'd1 : 4'd0;
      3'b001:  w_alu = 4'd6;
      3'b010:  w_alu = 4'd9;
      3'b011:  w_alu = 4'd10;
      3'b100:  w_alu = 4'd5;
      3'b101:  w_alu = r_ir[30] ? 4'd8 : 4'd7;
      3'b110:  w_alu = 4'd4;
      default: w_alu = 4'd3;
    endcase
  end

  always_comb begin
    inst_req    = 1'b0;
    ir_wen      = 1'b0;
    dmem_req    = 1'b0;
    dmem_wen    = 1'b0;
    dmem_funct3 = 3'd0;
    pc_wen      = 1'b0;
    reg_wen     = 1'b0;
    imm_type    = 3'd7;
    pc_src      = 1'b0;
    a_src       = 1'b0;
    b_src       = 1'b0;
    alu_op      = 4'd0;
    wb_src      = 2'd0;
    halt        = 1'b0;
    illegal     = r_ill;
    timeout     = r_to;
    // idle (and therefore reset) presents an all-zero bundle
    if (r_state == S_IDLE) imm_type = 3'd0;
    if (w_fields_vld) begin
      unique case (1'b1)
        w_lui:   begin imm_type = 3'd3; b_src = 1'b1; alu_op = 4'd2; end
        w_auipc: begin imm_type = 3'd3; a_src = 1'b1; b_src = 1'b1; end
        w_jal: begin
          imm_type = 3'd4; a_src = 1'b1; b_src = 1'b1; wb_src = 2'd1;
        end
        w_jalr:  begin imm_type = 3'd0; b_src = 1'b1; wb_src = 2'd1; end
        w_br:    begin imm_type = 3'd2; a_src = 1'b1; b_src = 1'b1; end
        w_ld:    begin imm_type = 3'd0; b_src = 1'b1; wb_src = 2'd2; end
        w_st:    begin imm_type = 3'd1; b_src = 1'b1; end
        w_opi:   begin imm_type = 3'd0; b_src = 1'b1; alu_op = w_alu; end
        w_op:    alu_op = w_alu;
        default: imm_type = 3'd7;
      endcase
    end
    unique case (r_state)
      S_FETCH: begin
        inst_req = 1'b1;
        ir_wen   = w_ir_wen;
      end
      S_MEM: begin
        dmem_req    = 1'b1;
        dmem_wen    = w_st;
        dmem_funct3 = r_ir[14:12];
        pc_wen      = w_st & dmem_resp_valid;
      end
      S_WB: begin
        pc_wen  = 1'b1;
        pc_src  = w_jal | w_jalr | (w_br & branch_taken);
        reg_wen = !w_br && (r_ir[11:7] != 5'd0);
      end
      S_HALT:  halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle output bundle
// compared against a transaction-level schedule built from the ISA rules.
module tb_multicycle_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_valid = 1'b0;
  logic [31:0] inst = '0;
  logic        branch_taken = 1'b0;
  logic        dmem_resp_valid = 1'b0;
  logic        inst_req, dmem_req, dmem_wen, ir_wen, pc_wen, reg_wen;
  logic [2:0]  dmem_funct3, imm_type;
  logic        pc_src, a_src, b_src, halt, illegal, timeout;
  logic [3:0]  alu_op;
  logic [1:0]  wb_src;

  multicycle_ctrl #(.TIMEOUT_CYCLES(TMO), .ENABLE_TIMEOUT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_valid(inst_valid), .inst(inst),
    .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen),
    .dmem_funct3(dmem_funct3), .dmem_resp_valid(dmem_resp_valid),
    .ir_wen(ir_wen), .pc_wen(pc_wen), .reg_wen(reg_wen),
    .imm_type(imm_type), .pc_src(pc_src), .a_src(a_src),
    .b_src(b_src), .alu_op(alu_op), .wb_src(wb_src),
    .halt(halt), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       inst_req, dmem_req, dmem_wen;
    logic [2:0] f3;
    logic       ir_wen, pc_wen, reg_wen;
    logic [2:0] imm_type;
    logic       pc_src, a_src, b_src;
    logic [3:0] alu_op;
    logic [1:0] wb_src;
    logic       halt, illegal, timeout;
  } obs_t;

  typedef enum int {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LD, C_ST, C_OPI, C_OP,
    C_EBRK, C_ILL
  } cls_t;

  typedef struct {
    logic        iv, rv, tk;
    logic [31:0] ins;
    obs_t        e;
    byte         ph;
  } cyc_t;

  obs_t w_obs;
  assign w_obs = {inst_req, dmem_req, dmem_wen, dmem_funct3, ir_wen,
                  pc_wen, reg_wen, imm_type, pc_src, a_src, b_src,
                  alu_op, wb_src, halt, illegal, timeout};

  int   n_cmp = 0;
  int   n_bad = 0;
  cyc_t q[$];
  logic [6:0] opc_tab [9] = '{7'b0110111, 7'b0010111, 7'b1101111,
                              7'b1100111, 7'b1100011, 7'b0000011,
                              7'b0100011, 7'b0010011, 7'b0110011};

  function automatic obs_t quiet();
    obs_t e = '0;
    e.imm_type = 3'd7;
    return e;
  endfunction

  function automatic cls_t cls_of(input logic [31:0] ins);
    if (ins == 32'h0010_0073) return C_EBRK;
    for (int k = 0; k < 9; k++)
      if (ins[6:0] == opc_tab[k]) return cls_t'(k);
    return C_ILL;
  endfunction

  // control fields an instruction should present in EXEC/MEM/WB
  function automatic obs_t fields(input logic [31:0] ins);
    obs_t f = quiet();
    cls_t c = cls_of(ins);
    int   f3tab [8] = '{0, 6, 9, 10, 5, 7, 4, 3};
    int   a;
    a = f3tab[ins[14:12]];
    if (ins[14:12] == 3'd0 && c == C_OP && ins[30]) a = 1;
    if (ins[14:12] == 3'd5 && ins[30]) a = 8;
    case (c)
      C_LUI:   begin f.imm_type = 3; f.b_src = 1; f.alu_op = 2; end
      C_AUIPC: begin f.imm_type = 3; f.a_src = 1; f.b_src = 1; end
      C_JAL:   begin
        f.imm_type = 4; f.a_src = 1; f.b_src = 1; f.wb_src = 1;
      end
      C_JALR:  begin f.imm_type = 0; f.b_src = 1; f.wb_src = 1; end
      C_BR:    begin f.imm_type = 2; f.a_src = 1; f.b_src = 1; end
      C_LD:    begin f.imm_type = 0; f.b_src = 1; f.wb_src = 2; end
      C_ST:    begin f.imm_type = 1; f.b_src = 1; end
      C_OPI:   begin f.imm_type = 0; f.b_src = 1; f.alu_op = 4'(a); end
      C_OP:    f.alu_op = 4'(a);
      default: ;
    endcase
    return f;
  endfunction

  function automatic void add(input logic iv, input logic rv,
                              input logic tk, input logic [31:0] ins,
                              input obs_t e, input byte ph);
    cyc_t c;
    c.iv = iv; c.rv = rv; c.tk = tk; c.ins = ins; c.e = e; c.ph = ph;
    q.push_back(c);
  endfunction

  function automatic void add_halt(input logic ill, input logic to);
    obs_t e;
    for (int k = 0; k < 3; k++) begin
      e = quiet(); e.halt = 1; e.illegal = ill; e.timeout = to;
      add(1'($urandom), 1'($urandom), 1'($urandom), $urandom, e, "H");
    end
  endfunction

  // df/dm: cycles before the valid; beyond TMO means it never comes
  function automatic void plan(input logic [31:0] ins, input int df,
                               input int dm, input logic tk);
    obs_t e, f;
    cls_t c;
    int   nf, nm;
    c  = cls_of(ins);
    f  = fields(ins);
    nf = (df > TMO) ? TMO + 1 : df + 1;
    for (int i = 0; i < nf; i++) begin
      e = quiet(); e.inst_req = 1; e.ir_wen = (i == df);
      add(i == df, 1'($urandom), 1'($urandom),
          (i == df) ? ins : $urandom, e, "F");
    end
    if (df > TMO) begin add_halt(0, 1); return; end
    add(1'($urandom), 1'($urandom), 1'($urandom), $urandom, quiet(), "D");
    if (c == C_EBRK || c == C_ILL) begin
      add_halt(c == C_ILL, 0);
      return;
    end
    add(1'($urandom), 1'($urandom), 1'($urandom), $urandom, f, "E");
    if (c == C_LD || c == C_ST) begin
      nm = (dm > TMO) ? TMO + 1 : dm + 1;
      for (int i = 0; i < nm; i++) begin
        e = f; e.dmem_req = 1; e.dmem_wen = (c == C_ST);
        e.f3 = ins[14:12];
        e.pc_wen = (c == C_ST) && (i == dm);
        add(1'($urandom), i == dm, 1'($urandom), $urandom, e, "M");
      end
      if (dm > TMO) begin add_halt(0, 1); return; end
      if (c == C_ST) return;
    end
    e = f; e.pc_wen = 1;
    e.pc_src = (c == C_JAL) || (c == C_JALR) || (c == C_BR && tk);
    e.reg_wen = (c != C_BR) && (ins[11:7] != 5'd0);
    add(1'($urandom), 1'($urandom), tk, $urandom, e, "W");
  endfunction

  task automatic do_inst(input logic [31:0] ins, input int df,
                         input int dm, input logic tk);
    cyc_t c;
    int   k = 0;
    plan(ins, df, dm, tk);
    while (q.size() > 0) begin
      c = q.pop_front();
      inst_valid = c.iv; dmem_resp_valid = c.rv;
      branch_taken = c.tk; inst = c.ins;
      @(negedge clk);
      n_cmp++;
      if (w_obs !== c.e) begin
        n_bad++;
        $display("FAIL inst %h cyc%0d(%c): got %h want %h",
                 ins, k, c.ph, w_obs, c.e);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic release_rst(input string nm);
    @(posedge clk); #1;
    rst = 0; inst_valid = 0; dmem_resp_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (w_obs !== '0) begin
      n_bad++;
      $display("FAIL %s idle: got %h want 0", nm, w_obs);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; inst_valid = 1; dmem_resp_valid = 1; #1;
    n_cmp++;
    if (w_obs !== '0) begin
      n_bad++;
      $display("FAIL reset: got %h want 0", w_obs);
    end
    @(posedge clk); #1;
    release_rst("reset");
  endtask

  task automatic test_addi();
    do_inst(32'h0050_0093, 1, 0, 0);
    do_inst(32'h0050_0013, 0, 0, 0);
  endtask

  task automatic test_branch();
    do_inst(32'h0000_0463, 0, 0, 1);
    do_inst(32'h0000_0463, 2, 0, 0);
  endtask

  task automatic test_load_store();
    do_inst(32'h0000_2183, 0, 3, 0);
    do_inst(32'h0030_2223, 1, 2, 0);
    do_inst(32'h4020_8133, 0, 0, 0);
    do_inst(32'h0000_2183, TMO, TMO, 0);
    do_inst(32'h0030_2223, 0, TMO, 0);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int n = 0; n < 80; n++) begin
      ins = $urandom;
      ins[6:0] = opc_tab[$urandom_range(0, 8)];
      do_inst(ins, $urandom_range(0, TMO), $urandom_range(0, TMO),
              1'($urandom));
    end
  endtask

  task automatic test_halts();
    do_inst(32'h0010_0073, 0, 0, 0);
    test_reset();
    do_inst(32'hFFFF_FFFF, 1, 0, 0);
    test_reset();
    do_inst(32'h0000_0073, 0, 0, 0);
    test_reset();
  endtask

  task automatic test_timeout();
    do_inst(32'h0050_0093, TMO + 1, 0, 0);
    test_reset();
    do_inst(32'h0000_2183, 0, TMO + 1, 0);
    test_reset();
    do_inst(32'h0030_2223, 2, TMO + 3, 0);
    test_reset();
  endtask

  task automatic test_reset_mid();
    inst_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (inst_req !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_fetch req: got %b want 1", inst_req);
    end
    #2 rst = 1; #1;
    n_cmp++;
    if (w_obs !== '0) begin
      n_bad++;
      $display("FAIL mid_fetch rst: got %h want 0", w_obs);
    end
    release_rst("mid_fetch");
    for (int k = 0; k < 4; k++) begin
      inst_valid = (k == 0); inst = 32'h0000_2183; dmem_resp_valid = 0;
      @(negedge clk);
      if (k < 3) begin @(posedge clk); #1; end
    end
    n_cmp++;
    if (dmem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_mem req: got %b want 1", dmem_req);
    end
    #2 rst = 1; #1;
    n_cmp++;
    if (w_obs !== '0) begin
      n_bad++;
      $display("FAIL mid_mem rst: got %h want 0", w_obs);
    end
    release_rst("mid_mem");
    do_inst(32'h0050_0093, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_addi();
    test_branch();
    test_load_store();
    test_random();
    test_halts();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
